seq_array_multiplier: RTL
=========================

# seq_array_multiplier

Parametrised, iterative shift-add multiplier: the sequential, multi-width successor of the team's 4x4 combinational array multiplier. It takes two WIDTH-bit operands through a valid/ready handshake and computes one partial-product row per clock. It returns a 2*WIDTH-bit product through a second valid/ready handshake. Optional signed (two's-complement) mode is selectable per operation. It sits between operand-producing datapath logic and any consumer that can tolerate WIDTH-cycle latency in exchange for roughly WIDTH full-adders of area instead of WIDTH².

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- sgn  input  1  1 = treat a, b as two's-complement (only with MULT_SIGNED_EN).
- out_valid  output  1  p holds a valid product.
- out_ready  input  1  consumer accepts p this cycle.
- p  output  2*WIDTH  product.
- busy  output  1  high while in RUN.

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (IDLE) or (DONE and out_ready).
- An operation is accepted on any edge with in_valid and in_ready high. On accept:
  - capture mcand = |a| and the product register P = {WIDTH'b0, |b|};
  - neg = a[W-1]^b[W-1] when signed, else 0;
  - cnt = WIDTH-1; go to RUN.
- Magnitudes are taken only when signed is active; otherwise raw values are used.
- The magnitude of -2^(W-1) is 2^(W-1), which fits unsigned in WIDTH bits.
- RUN, each edge:
  - if P[0], add mcand to P[2W-1:W], with the carry kept in a (W+1)-bit sum;
  - shift the (2W+1)-bit result right by 1 into P.
- When cnt==0 in RUN:
  - load p = neg ? (~Pnext+1) : Pnext, modulo 2^(2W);
  - go to DONE. Otherwise decrement cnt.
- DONE:
  - out_valid=1; p is held stable until the out_ready handshake completes;
  - on out_ready, either accept a new operation (in_valid) and go to RUN, or go to IDLE.
- in_valid while in RUN is ignored. Operands a, b, sgn need only be valid in the accept cycle.
- Full-range results are exact: (-2^(W-1))² = 2^(2W-2) is representable in 2W signed bits.
- Reset (asynchronous, at any time including mid-RUN or in DONE) forces:
  - state=IDLE;
  - p=0, out_valid=0, busy=0;
  - P, mcand, cnt, neg cleared.
  - in_ready=1 while rst_n is low and after release.
- The operation in flight is discarded; no output is produced for it.

## Timing
- Latency: operands accepted on edge t; out_valid rises after edge t+WIDTH.
- busy is high from edge t+1 through edge t+WIDTH.
- Back-to-back throughput with out_ready held high: one product per WIDTH+1 cycles, because DONE overlaps with the next accept.
- out_valid falls on the edge after the handshake unless a new operation is in DONE.
- in_ready and out_valid are the only combinationally derived outputs; in_ready depends on out_ready.
- No combinational path from a, b, or in_valid to any output.

## Configuration
- MULT_SIGNED_EN defined:
  - sgn is honoured per operation;
  - magnitude and negation logic is compiled in.
- MULT_SIGNED_EN undefined:
  - sgn is ignored; all operations are unsigned;
  - neg is forced 0 and the negation/abs logic is removed.

## Test plan
- WIDTH=4, unsigned, a=13, b=11, out_ready=1 → out_valid 4 cycles after accept, p=8'h8F (143); busy high exactly 4 cycles.
- WIDTH=4, MULT_SIGNED_EN, sgn=1:
  - a=4'h8, b=4'h8 → p=8'h40 (64);
  - a=4'hD (-3), b=4'h5 → p=8'hF1 (-15).
- WIDTH=8, out_ready held low 6 cycles after out_valid → p=a*b stable, in_ready=0 throughout.
- Same case, continued: raise out_ready with in_valid high → next operation accepted the same edge, next out_valid WIDTH cycles later.
- Reset mid-RUN (WIDTH=8, rst_n low at cycle 3 after accept) → immediately p=0, out_valid=0, busy=0, in_ready=1; next operation computes correctly.
- Without MULT_SIGNED_EN, WIDTH=4, sgn=1, a=4'hF, b=4'hF → p=8'hE1 (225).
- Exhaustive WIDTH=4, unsigned and signed (where enabled), random out_ready → every p matches a reference product; no lost or duplicated results.

Source files
------------

// File: rtl/seq_array_multiplier.sv
// ---------------------------------------------------------------------------
// seq_array_multiplier
//
// Iterative shift-add multiplier. Each clock adds one partial-product row, so
// a WIDTH x WIDTH product is ready WIDTH cycles after the operands are
// accepted. Operands enter through one valid/ready handshake and the
// 2*WIDTH-bit product leaves through a second one.
//
// Compile-time option:
//   MULT_SIGNED_EN  - when defined, sgn selects two's-complement operation
//                     for each operation. The core multiplies magnitudes and
//                     negates the result at the end. When undefined, sgn is
//                     ignored and every operation is unsigned.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   block can accept operands this cycle
//   a, b       multiplicand / multiplier (WIDTH bits)
//   sgn        1 = signed operation (only with MULT_SIGNED_EN)
//   out_valid  p holds a valid product
//   out_ready  consumer accepts p this cycle
//   p          product (2*WIDTH bits)
//   busy       high while iterating
// ---------------------------------------------------------------------------
module seq_array_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [PW-1:0]     prod_reg;
    logic [PW-1:0]     prod_next;
    logic [PW-1:0]     p_reg;
    logic [PW-1:0]     p_load;
    logic [WIDTH-1:0]  mcand_reg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    sum;
    logic [CW-1:0]     cnt_reg;
    logic              busy_reg;
    logic              accept;
    logic              last_step;

`ifdef MULT_SIGNED_EN
    logic              neg_reg;
    logic              neg_in;

    // Work on magnitudes. |-2^(W-1)| = 2^(W-1) still fits unsigned in WIDTH bits.
    assign neg_in = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign a_mag  = (sgn & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag  = (sgn & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign p_load = neg_reg ? (~prod_next + PW'(1)) : prod_next;
`else
    logic              unused_sgn;

    assign unused_sgn = sgn;
    assign a_mag      = a;
    assign b_mag      = b;
    assign p_load     = prod_next;
`endif

    // One row per clock. The upper half gains mcand when the current
    // multiplier bit (LSB) is set. The carry is kept in bit WIDTH of sum so
    // the right shift brings it into the top of the product.
    assign sum       = {1'b0, prod_reg[PW-1:WIDTH]}
                     + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
    assign prod_next = {sum, prod_reg[WIDTH-1:1]};
    assign last_step = (cnt_reg == '0);
    assign accept    = in_valid & in_ready;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // in_valid is ignored here because in_ready stays low.
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // The result slot frees up on the same edge that it is
                // consumed, so a new operation can overlap the handshake.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_reg  <= '0;
            mcand_reg <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
            busy_reg  <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_reg   <= 1'b0;
`endif
        end else if (accept) begin
            mcand_reg <= a_mag;
            prod_reg  <= {{WIDTH{1'b0}}, b_mag};
            cnt_reg   <= CW'(WIDTH - 1);
            busy_reg  <= 1'b1;
`ifdef MULT_SIGNED_EN
            neg_reg   <= neg_in;
`endif
        end else if (state_reg == RUN) begin
            prod_reg <= prod_next;
            if (last_step) begin
                // p only changes here, so it stays stable through DONE.
                p_reg    <= p_load;
                busy_reg <= 1'b0;
            end else begin
                cnt_reg  <= cnt_reg - CW'(1);
            end
        end
    end

    assign p    = p_reg;
    assign busy = busy_reg;

endmodule
